// File: rtl/shiftreg_out_ctl_if.sv
// Parallel-word handshake plus serial shift-register chain pins for shiftreg_out_ctl.
// The master side offers words; the slave side owns the shift chain and status.
interface shiftreg_out_ctl_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;
    logic             sr_clk;
    logic             sr_data;
    logic             sr_latch;
    logic             sr_oen;
    logic             done;

    modport master (
        output data, valid,
        input  ready, sr_clk, sr_data, sr_latch, sr_oen, done
    );

    modport slave (
        input  data, valid,
        output ready, sr_clk, sr_data, sr_latch, sr_oen, done
    );
endinterface

// File: rtl/shiftreg_out_ctl.sv
// Drives a serial-in/parallel-out register chain: shifts a captured word out MSB first, then
// pulses the storage latch. Optional macro SHIFTREG_OUT_AUTOREFRESH_EN re-sends the last word.
module shiftreg_out_ctl #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DIV_BITS = 8
) (
    input logic                clock_50m,
    input logic                reset,
    shiftreg_out_ctl_if.slave  bus
);

    localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StShiftLo,
        StShiftHi,
        StLatchHi,
        StLatchLo
    } state_e;

    state_e              state_q, state_d;
    logic [DIV_BITS-1:0] phase_q, phase_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [WIDTH-1:0]    shadow_q, shadow_d;
    logic                ready_q, ready_d;
    logic                sr_clk_q, sr_clk_d;
    logic                sr_data_q, sr_data_d;
    logic                sr_latch_q, sr_latch_d;
    logic                sr_oen_q, sr_oen_d;
    logic                done_q, done_d;
`ifdef SHIFTREG_OUT_AUTOREFRESH_EN
    logic                have_word_q, have_word_d;
`endif

    logic phase_end;
    logic accept;

    // Every non-idle state lasts exactly 2^DIV_BITS cycles: leave when the counter is all ones.
    assign phase_end = &phase_q;
    assign accept    = bus.valid & ready_q;

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q + DIV_BITS'(1);
        idx_d    = idx_q;
        shadow_d = shadow_q;
        sr_oen_d = sr_oen_q;
`ifdef SHIFTREG_OUT_AUTOREFRESH_EN
        have_word_d = have_word_q;
`endif

        unique case (state_q)
            StIdle: begin
                phase_d = '0;
                if (accept) begin
                    shadow_d = bus.data;
                    idx_d    = IdxW'(WIDTH - 1);
                    state_d  = StShiftLo;
`ifdef SHIFTREG_OUT_AUTOREFRESH_EN
                    have_word_d = 1'b1;
`endif
                end
`ifdef SHIFTREG_OUT_AUTOREFRESH_EN
                else if (have_word_q) begin
                    idx_d   = IdxW'(WIDTH - 1);
                    state_d = StShiftLo;
                end
`endif
            end
            StShiftLo: begin
                if (phase_end) begin
                    phase_d = '0;
                    state_d = StShiftHi;
                end
            end
            StShiftHi: begin
                if (phase_end) begin
                    phase_d = '0;
                    if (idx_q != '0) begin
                        idx_d   = idx_q - IdxW'(1);
                        state_d = StShiftLo;
                    end else begin
                        state_d = StLatchHi;
                    end
                end
            end
            StLatchHi: begin
                if (phase_end) begin
                    phase_d = '0;
                    state_d = StLatchLo;
                end
            end
            StLatchLo: begin
                if (phase_end) begin
                    phase_d  = '0;
                    state_d  = StIdle;
                    sr_oen_d = 1'b0;
                end
            end
            default: begin
                phase_d = '0;
                state_d = StIdle;
            end
        endcase

        // Outputs are decoded from the next state so they are registered yet aligned to it.
        ready_d    = (state_d == StIdle);
        sr_clk_d   = (state_d == StShiftHi);
        sr_latch_d = (state_d == StLatchHi);
        done_d     = (state_d == StLatchLo) && (&phase_d);
        sr_data_d  = sr_data_q;
        if (state_d == StShiftLo || state_d == StShiftHi) begin
            sr_data_d = shadow_d[idx_d];
        end
    end

    always_ff @(posedge clock_50m) begin
        if (reset) begin
            state_q    <= StIdle;
            phase_q    <= '0;
            idx_q      <= '0;
            shadow_q   <= '0;
            ready_q    <= 1'b1;
            sr_clk_q   <= 1'b0;
            sr_data_q  <= 1'b0;
            sr_latch_q <= 1'b0;
            sr_oen_q   <= 1'b1;
            done_q     <= 1'b0;
`ifdef SHIFTREG_OUT_AUTOREFRESH_EN
            have_word_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            ready_q    <= ready_d;
            sr_clk_q   <= sr_clk_d;
            sr_data_q  <= sr_data_d;
            sr_latch_q <= sr_latch_d;
            sr_oen_q   <= sr_oen_d;
            done_q     <= done_d;
`ifdef SHIFTREG_OUT_AUTOREFRESH_EN
            have_word_q <= have_word_d;
`endif
        end
    end

    assign bus.ready    = ready_q;
    assign bus.sr_clk   = sr_clk_q;
    assign bus.sr_data  = sr_data_q;
    assign bus.sr_latch = sr_latch_q;
    assign bus.sr_oen   = sr_oen_q;
    assign bus.done     = done_q;

    sr_clk_latch_excl: assert property (@(posedge clock_50m) disable iff (reset)
        !(sr_clk_q && sr_latch_q));

    sr_data_stable_hi: assert property (@(posedge clock_50m) disable iff (reset)
        sr_clk_q |=> (!sr_clk_q || $stable(sr_data_q)));

endmodule
